// File: rtl/dem_switch_seq_gen.sv
// DEM switching-sequence generator for one tree layer.
// A shared 16-bit Galois LFSR supplies the random decision bits and PN swap
// bits. Each node runs a three-state first-order shaper so its sequence is
// zero on even inputs, +/-1 on odd inputs, and its running sum stays in [-1,+1].

module dem_switch_node (
   input  logic clk_i,
   input  logic reset_i,
   input  logic step_i,
   input  logic x_lsb_i,
   input  logic rnd_i,
   output logic s_pos_o,
   output logic s_neg_o
);

   typedef enum logic [1:0] {ST_ZERO = 2'd0, ST_POS = 2'd1, ST_NEG = 2'd2} state_t;

   state_t state_q, state_nxt;

   // State register: the running sum of emitted values.
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= ST_ZERO;
      else         state_q <= state_nxt;
   end

   // Next state: odd inputs toggle away from / back to zero; even inputs hold.
   always_comb begin
      state_nxt = state_q;
      if (step_i && x_lsb_i) begin
         case (state_q)
            ST_ZERO: state_nxt = rnd_i ? ST_POS : ST_NEG;
            ST_POS:  state_nxt = ST_ZERO;
            ST_NEG:  state_nxt = ST_ZERO;
            default: state_nxt = ST_ZERO;
         endcase
      end
   end

   // Output: value for this sample, chosen to pull the running sum back to zero.
   always_comb begin
      s_pos_o = 1'b0;
      s_neg_o = 1'b0;
      if (x_lsb_i) begin
         case (state_q)
            ST_ZERO: begin
               s_pos_o = rnd_i;
               s_neg_o = ~rnd_i;
            end
            ST_POS:  s_neg_o = 1'b1;
            ST_NEG:  s_pos_o = 1'b1;
            default: s_neg_o = 1'b0;
         endcase
      end
   end

endmodule

module dem_switch_seq_gen #(
   parameter int          WIDTH = 16,
   parameter int          NODES = 4,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     en_i,
   input  logic                     seed_load_i,
   input  logic [15:0]              seed_i,
   input  logic [NODES-1:0]         x_lsb_i,
   output logic [NODES-1:0]         pn_seq_o,
   output logic [NODES*WIDTH-1:0]   quantized_value_o,
   output logic                     valid_o
);

   logic [15:0]                  lfsr_q;
   logic [15:0]                  lfsr_nxt;
   logic                         step;
   logic [NODES-1:0]             s_pos;
   logic [NODES-1:0]             s_neg;
   logic [NODES-1:0][WIDTH-1:0]  word_d;
   logic [NODES-1:0][WIDTH-1:0]  word_q;
   logic [NODES-1:0]             pn_q;
   logic                         valid_q;

   // A seed load swallows any step requested in the same cycle.
   assign step = en_i & ~seed_load_i;

   // Galois right-shift LFSR, taps x^16+x^14+x^13+x^11+1.
   always_comb begin
      lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   end

   // Node i draws its decision bit from the top of the LFSR and its PN bit from
   // the bottom, so the two never alias for up to eight nodes.
   for (genvar g = 0; g < NODES; g++) begin : g_node
      dem_switch_node u_node (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .step_i  (step),
         .x_lsb_i (x_lsb_i[g]),
         .rnd_i   (lfsr_q[15-g]),
         .s_pos_o (s_pos[g]),
         .s_neg_o (s_neg[g])
      );

      // Two's complement encoding: -1 is all ones, +1 is a lone LSB.
      always_comb begin
         word_d[g] = s_neg[g] ? {WIDTH{1'b1}} : {{(WIDTH-1){1'b0}}, s_pos[g]};
      end
   end

   // LFSR and output registers; outputs only change on an accepted step.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lfsr_q  <= SEED;
         pn_q    <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else if (seed_load_i) begin
         lfsr_q  <= (seed_i == 16'h0000) ? SEED : seed_i;
         valid_q <= 1'b0;
      end else if (en_i) begin
         lfsr_q  <= lfsr_nxt;
         pn_q    <= lfsr_q[NODES-1:0];
         word_q  <= word_d;
         valid_q <= 1'b1;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign pn_seq_o          = pn_q;
   assign quantized_value_o = word_q;
   assign valid_o           = valid_q;

endmodule
